mcast_fork_rt: RTL and testbench

- Registered route-computation and multicast-forking unit for one router input port in the X_DIM x Y_DIM mesh.
- It accepts a head-flit destination descriptor, either a unicast node index or a multicast destination bitmap, and sorts every destination by its DOR output port.
- It then emits one route beat per non-empty output port, each carrying the subset bitmap for that branch, under a valid/ready handshake.
- This replaces single-next-hop multicast decoding with true tree forking, and makes mesh size and routing mode parameters.

---
 rtl/mcast_fork_rt.sv | 151 +++++++++++++++
 tb/tb_mcast_fork_rt.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcast_fork_rt.sv
// Route computation and multicast tree forking for one mesh router input port.
// A descriptor is split by DOR output port and emitted as one beat per non-empty branch.
module mcast_fork_rt #(
    parameter int X_DIM   = 5,
    parameter int Y_DIM   = 4,
    parameter int MY_XPOS = 0,
    parameter int MY_YPOS = 0,
    parameter int ROUTING = 0,
    localparam int N      = X_DIM * Y_DIM,
    localparam int UW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mcast,
    input  logic [UW-1:0] in_uaddr,
    input  logic [N-1:0]  in_maddr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_port,
    output logic [N-1:0]  out_maddr,
    output logic          out_mcast,
    output logic          out_last,
    output logic          err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_EAST  = 3'd1;
    localparam logic [2:0] P_WEST  = 3'd2;
    localparam logic [2:0] P_NORTH = 3'd3;
    localparam logic [2:0] P_SOUTH = 3'd4;

    // Router position is a parameter, so each node's output port is a constant.
    function automatic logic [2:0] port_of(input int k);
        int dx;
        int dy;
        logic [2:0] p;
        dx = k / Y_DIM;
        dy = k % Y_DIM;
        p  = P_LOCAL;
        if (ROUTING == 0) begin
            if (dx > MY_XPOS)      p = P_EAST;
            else if (dx < MY_XPOS) p = P_WEST;
            else if (dy > MY_YPOS) p = P_NORTH;
            else if (dy < MY_YPOS) p = P_SOUTH;
        end else begin
            if (dy > MY_YPOS)      p = P_NORTH;
            else if (dy < MY_YPOS) p = P_SOUTH;
            else if (dx > MY_XPOS) p = P_EAST;
            else if (dx < MY_XPOS) p = P_WEST;
        end
        return p;
    endfunction

    logic [0:0]          state_q;
    logic [4:0]          pend_q;
    logic [4:0][N-1:0]   sub_q;
    logic                mcast_q;
    logic                err_q;

    logic [N-1:0]        dest;
    logic                drop;
    logic [4:0][N-1:0]   part;
    logic [4:0]          mask;
    logic [2:0]          sel;
    logic [4:0]          sel_oh;
    logic                emit;
    logic                last;

    always_comb begin
        dest = '0;
        drop = 1'b0;
        if (in_mcast) begin
            dest = in_maddr;
            drop = (in_maddr == '0);
        end else if (32'(in_uaddr) >= 32'(N)) begin
            drop = 1'b1;
        end else begin
            dest = {{(N-1){1'b0}}, 1'b1} << in_uaddr;
        end
    end

    always_comb begin
        part = '0;
        mask = '0;
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < N; k++) begin
                part[p][k] = dest[k] && (port_of(k) == 3'(p));
            end
            mask[p] = |part[p];
        end
    end

    // Lowest-numbered pending port wins: LOCAL, EAST, WEST, NORTH, SOUTH.
    always_comb begin
        sel = 3'd0;
        for (int p = 4; p >= 0; p--) begin
            if (pend_q[p]) sel = 3'(p);
        end
    end

    assign sel_oh = 5'b00001 << sel;
    assign emit   = (state_q == ST_EMIT);
    assign last   = ((pend_q & ~sel_oh) == 5'b00000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            sub_q   <= '0;
            mcast_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (drop) begin
                            err_q <= 1'b1;
                        end else begin
                            sub_q   <= part;
                            pend_q  <= mask;
                            mcast_q <= in_mcast;
                            if (mask != 5'b00000) state_q <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        pend_q <= pend_q & ~sel_oh;
                        if (last) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = !emit;
    assign out_valid = emit;
    assign out_port  = emit ? sel : 3'd0;
    assign out_maddr = emit ? sub_q[sel] : '0;
    assign out_mcast = emit ? mcast_q : 1'b0;
    assign out_last  = emit ? last : 1'b0;
    assign err       = err_q;

endmodule

// File: tb/tb_mcast_fork_rt.sv
// Bench for mcast_fork_rt at node (1,2) of a 5x4 mesh, XY and YX instances side by side.
// A queue-based route model predicts every beat; directed literals pin the model.
module tb_mcast_fork_rt;

    localparam int N  = 20;
    localparam int UW = 5;

    typedef struct packed {
        logic [2:0]   port;
        logic [N-1:0] maddr;
        logic         mcast;
        logic         last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_mcast = 1'b0;
    logic [UW-1:0] in_uaddr = '0;
    logic [N-1:0]  in_maddr = '0;
    logic          out_ready = 1'b1;

    logic          rdy_x, val_x, mc_x, last_x, err_x;
    logic [2:0]    port_x;
    logic [N-1:0]  ma_x;
    logic          rdy_y, val_y, mc_y, last_y, err_y;
    logic [2:0]    port_y;
    logic [N-1:0]  ma_y;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    beat_t qx[$];
    beat_t qy[$];
    beat_t cap_x[$];
    beat_t cap_y[$];
    logic  exp_err_x, exp_err_y;

    always #5 clk = ~clk;

    mcast_fork_rt #(.X_DIM(5), .Y_DIM(4), .MY_XPOS(1), .MY_YPOS(2), .ROUTING(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_x),
        .in_mcast(in_mcast), .in_uaddr(in_uaddr), .in_maddr(in_maddr),
        .out_valid(val_x), .out_ready(out_ready), .out_port(port_x), .out_maddr(ma_x),
        .out_mcast(mc_x), .out_last(last_x), .err(err_x)
    );

    mcast_fork_rt #(.X_DIM(5), .Y_DIM(4), .MY_XPOS(1), .MY_YPOS(2), .ROUTING(1)) dut_yx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_y),
        .in_mcast(in_mcast), .in_uaddr(in_uaddr), .in_maddr(in_maddr),
        .out_valid(val_y), .out_ready(out_ready), .out_port(port_y), .out_maddr(ma_y),
        .out_mcast(mc_y), .out_last(last_y), .err(err_y)
    );

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h want 0x%0h at %0t", name, id, act, exp, $time);
        end
    endtask

    // Destination sets by coordinate: node k sits at x=k/4, y=k%4; this router is (1,2).
    function automatic void route_model(input logic mc, input logic [UW-1:0] ua,
                                        input logic [N-1:0] ma, input int routing,
                                        output logic [4:0][N-1:0] sub, output logic drop);
        logic [N-1:0] d;
        int x, y, p;
        sub  = '0;
        d    = '0;
        drop = 1'b0;
        if (mc) begin
            d = ma;
            if (ma == '0) drop = 1'b1;
        end else if (int'(ua) >= N) begin
            drop = 1'b1;
        end else begin
            d[ua] = 1'b1;
        end
        for (int k = 0; k < N; k++) begin
            if (d[k]) begin
                x = k / 4;
                y = k % 4;
                if (x == 1 && y == 2)                p = 0;
                else if (routing == 0 && x != 1)     p = (x > 1) ? 1 : 2;
                else if (routing == 0)               p = (y > 2) ? 3 : 4;
                else if (y != 2)                     p = (y > 2) ? 3 : 4;
                else                                 p = (x > 1) ? 1 : 2;
                sub[p][k] = 1'b1;
            end
        end
    endfunction

    task automatic push_beats(input int id, input logic mc, input logic [4:0][N-1:0] sub);
        int cnt, n;
        beat_t b;
        cnt = 0;
        n   = 0;
        for (int p = 0; p < 5; p++) if (sub[p] != '0) cnt++;
        for (int p = 0; p < 5; p++) begin
            if (sub[p] != '0) begin
                n++;
                b.port  = 3'(p);
                b.maddr = sub[p];
                b.mcast = mc;
                b.last  = (n == cnt);
                if (id == 0) qx.push_back(b);
                else qy.push_back(b);
            end
        end
    endtask

    logic [4:0][N-1:0] sub_m;
    logic              drop_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qx.delete();
            qy.delete();
            exp_err_x <= 1'b0;
            exp_err_y <= 1'b0;
        end else begin
            exp_err_x <= 1'b0;
            exp_err_y <= 1'b0;
            if (qx.size() == 0) begin
                if (in_valid) begin
                    route_model(in_mcast, in_uaddr, in_maddr, 0, sub_m, drop_m);
                    if (drop_m) exp_err_x <= 1'b1;
                    else push_beats(0, in_mcast, sub_m);
                end
            end else if (out_ready) begin
                void'(qx.pop_front());
            end
            if (qy.size() == 0) begin
                if (in_valid) begin
                    route_model(in_mcast, in_uaddr, in_maddr, 1, sub_m, drop_m);
                    if (drop_m) exp_err_y <= 1'b1;
                    else push_beats(1, in_mcast, sub_m);
                end
            end else if (out_ready) begin
                void'(qy.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && val_x && out_ready) cap_x.push_back({port_x, ma_x, mc_x, last_x});
        if (rst_n && val_y && out_ready) cap_y.push_back({port_y, ma_y, mc_y, last_y});
    end

    task automatic cmp_dut(input int id, input logic v, input logic rdy, input logic [2:0] pt,
                           input logic [N-1:0] ma, input logic mc, input logic lst,
                           input logic er);
        beat_t e;
        logic busy;
        logic ee;
        e = '0;
        if (id == 0) begin
            busy = (qx.size() != 0);
            if (busy) e = qx[0];
            ee = exp_err_x;
        end else begin
            busy = (qy.size() != 0);
            if (busy) e = qy[0];
            ee = exp_err_y;
        end
        chk("in_ready", id, 32'(rdy), 32'(!busy));
        chk("out_valid", id, 32'(v), 32'(busy));
        chk("err", id, 32'(er), 32'(ee));
        if (busy && v) begin
            chk("out_port", id, 32'(pt), 32'(e.port));
            chk("out_maddr", id, 32'(ma), 32'(e.maddr));
            chk("out_mcast", id, 32'(mc), 32'(e.mcast));
            chk("out_last", id, 32'(lst), 32'(e.last));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            cmp_dut(0, val_x, rdy_x, port_x, ma_x, mc_x, last_x, err_x);
            cmp_dut(1, val_y, rdy_y, port_y, ma_y, mc_y, last_y, err_y);
        end
    end

    task automatic send(input logic mc, input logic [UW-1:0] ua, input logic [N-1:0] ma);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_mcast = mc;
        in_uaddr = ua;
        in_maddr = ma;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_uaddr = '0;
        in_maddr = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((val_x || val_y) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 0, 32'(val_x || val_y), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input int id, input logic rdy, input logic v,
                                  input logic [2:0] pt, input logic [N-1:0] ma,
                                  input logic mc, input logic lst, input logic er);
        chk("rst_in_ready", id, 32'(rdy), 32'd1);
        chk("rst_out_valid", id, 32'(v), 32'd0);
        chk("rst_out_port", id, 32'(pt), 32'd0);
        chk("rst_out_maddr", id, 32'(ma), 32'd0);
        chk("rst_out_mcast", id, 32'(mc), 32'd0);
        chk("rst_out_last", id, 32'(lst), 32'd0);
        chk("rst_err", id, 32'(er), 32'd0);
    endtask

    logic [2:0]   lit_port [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [N-1:0] lit_maddr[5] = '{20'h00040, 20'h04400, 20'h00004, 20'h00080, 20'h00020};

    task automatic chk_fork_capture();
        chk("fork_count", 0, 32'(cap_x.size()), 32'd5);
        for (int i = 0; i < 5 && i < cap_x.size(); i++) begin
            chk("fork_port", 0, 32'(cap_x[i].port), 32'(lit_port[i]));
            chk("fork_maddr", 0, 32'(cap_x[i].maddr), 32'(lit_maddr[i]));
            chk("fork_last", 0, 32'(cap_x[i].last), 32'(i == 4));
        end
    endtask

    logic [1:0] bp_pat [6] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1};

    initial begin
        logic [4:0][N-1:0] s;
        logic dr;
        int n;

        // Model pins against hand-derived partitions.
        route_model(1'b1, '0, 20'h044E4, 0, s, dr);
        chk("model_fork", 0, 32'(s[1]), 32'h04400);
        chk("model_fork_s", 0, 32'(s[4]), 32'h00020);
        route_model(1'b1, '0, 20'h80000, 1, s, dr);
        chk("model_yx", 1, 32'(s[3]), 32'h80000);
        route_model(1'b0, 5'd20, '0, 0, s, dr);
        chk("model_drop", 0, 32'(dr), 32'd1);

        #1;
        chk_reset_vals(0, rdy_x, val_x, port_x, ma_x, mc_x, last_x, err_x);
        chk_reset_vals(1, rdy_y, val_y, port_y, ma_y, mc_y, last_y, err_y);
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Full five-way fork.
        cap_x.delete();
        send(1'b1, '0, 20'h044E4);
        chk("lat_valid", 0, 32'(val_x), 32'd1);
        wait_idle(20);
        chk_fork_capture();

        // Routing mode: single far-corner destination.
        cap_x.delete();
        cap_y.delete();
        send(1'b1, '0, 20'h80000);
        wait_idle(20);
        chk("xy_count", 0, 32'(cap_x.size()), 32'd1);
        if (cap_x.size() > 0) chk("xy_beat", 0, 32'(cap_x[0]), 32'({3'd1, 20'h80000, 1'b1, 1'b1}));
        chk("yx_count", 1, 32'(cap_y.size()), 32'd1);
        if (cap_y.size() > 0) chk("yx_beat", 1, 32'(cap_y[0]), 32'({3'd3, 20'h80000, 1'b1, 1'b1}));

        // Unicast.
        cap_x.delete();
        send(1'b0, 5'd13, '0);
        chk("uc_valid", 0, 32'(val_x), 32'd1);
        chk("uc_port", 0, 32'(port_x), 32'd1);
        chk("uc_maddr", 0, 32'(ma_x), 32'h02000);
        chk("uc_mcast", 0, 32'(mc_x), 32'd0);
        chk("uc_last", 0, 32'(last_x), 32'd1);
        wait_idle(20);
        send(1'b0, 5'd6, '0);
        chk("uc_local_port", 0, 32'(port_x), 32'd0);
        chk("uc_local_maddr", 0, 32'(ma_x), 32'h00040);
        wait_idle(20);

        // Backpressure on the five-way fork.
        cap_x.delete();
        send(1'b1, '0, 20'h044E4);
        n = 0;
        while ((val_x || val_y) && n < 60) begin
            out_ready = bp_pat[n % 6][0];
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b1;
        chk("bp_timeout", 0, 32'(val_x || val_y), 32'd0);
        chk_fork_capture();
        @(posedge clk);
        #1;

        // Dropped descriptors.
        send(1'b1, '0, '0);
        chk("drop_m_err", 0, 32'(err_x), 32'd1);
        chk("drop_m_valid", 0, 32'(val_x), 32'd0);
        @(posedge clk);
        #1;
        chk("drop_m_err_end", 0, 32'(err_x), 32'd0);
        send(1'b0, 5'd20, '0);
        chk("drop_u_err", 0, 32'(err_x), 32'd1);
        chk("drop_u_valid", 0, 32'(val_x), 32'd0);
        @(posedge clk);
        #1;
        chk("drop_u_err_end", 0, 32'(err_x), 32'd0);

        // Asynchronous reset after the second beat.
        cap_x.delete();
        send(1'b1, '0, 20'h044E4);
        n = 0;
        while (cap_x.size() < 2 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_beats_seen", 0, 32'(cap_x.size()), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals(0, rdy_x, val_x, port_x, ma_x, mc_x, last_x, err_x);
        chk_reset_vals(1, rdy_y, val_y, port_y, ma_y, mc_y, last_y, err_y);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 0, 32'(rdy_x), 32'd1);
        chk("post_rst_beats", 0, 32'(cap_x.size()), 32'd2);
        cap_x.delete();
        send(1'b0, 5'd13, '0);
        wait_idle(20);
        chk("post_rst_count", 0, 32'(cap_x.size()), 32'd1);
        if (cap_x.size() > 0) chk("post_rst_beat", 0, 32'(cap_x[0]), 32'({3'd1, 20'h02000, 1'b0, 1'b1}));

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
